// File: rtl/serial_tx.sv
// 8N1 serial transmitter with a small circular byte FIFO in front of it.
// One start bit, eight data bits LSB first, one stop bit, each RCONST clocks long.
module serial_tx #(
    parameter int unsigned RCONST     = 868,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            tx_byte,
    input  logic                  tx_wr,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  tx_busy,
    output logic                  tx
);

    localparam int unsigned        DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [15:0]        BIT_LAST   = 16'(RCONST - 1);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state;
    logic [15:0]            bit_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_reg;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    level_next;
    logic                   push;
    logic                   pop;
    logic                   bit_end;

    assign bit_end = (bit_cnt == BIT_LAST);
    assign push    = tx_wr && !tx_full;
    // Pop from IDLE, or at the very end of a stop bit so frames run back-to-back.
    assign pop     = (fifo_level != '0) && ((state == IDLE) || (state == STOP && bit_end));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        level_next = fifo_level;
        if (push && !pop)
            level_next = fifo_level + 1'b1;
        else if (pop && !push)
            level_next = fifo_level - 1'b1;
    end

    // NOTE: storage has no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_byte;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            tx_full    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_next;
            tx_full    <= (level_next == FULL_LEVEL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= START;
                        shift_reg <= mem[rd_ptr];
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                        tx      <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            state     <= START;
                            shift_reg <= mem[rd_ptr];
                            tx        <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a frame-timing model predicts tx, tx_busy,
// fifo_level and tx_full on every clock, with directed and random stimulus.
module tb_serial_tx;

    localparam int R     = 16;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * R;

    logic         clk;
    logic         rst_n;
    logic [7:0]   tx_byte;
    logic         tx_wr;
    logic         tx_full;
    logic [DL2:0] fifo_level;
    logic         tx_busy;
    logic         tx;

    serial_tx #(.RCONST(R), .DEPTH_LOG2(DL2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_byte    (tx_byte),
        .tx_wr      (tx_wr),
        .tx_full    (tx_full),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queued bytes, byte on the line, and cycles left in the current frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    int         m_rem;
    logic       m_tx;
    logic       m_busy;
    int         m_level;
    logic       m_full;

    task automatic model_reset();
        m_q.delete();
        m_rem   = 0;
        m_cur   = 8'h00;
        m_tx    = 1'b1;
        m_busy  = 1'b0;
        m_level = 0;
        m_full  = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic cycle(input logic wr, input logic [7:0] b);
        bit full_before;
        int k;
        tx_wr   = wr;
        tx_byte = b;
        @(posedge clk);
        full_before = (m_q.size() == DEPTH);
        if (m_rem > 0) m_rem--;
        if (m_rem == 0 && m_q.size() != 0) begin
            m_cur = m_q.pop_front();
            m_rem = FRAME;
        end
        if (wr && !full_before) m_q.push_back(b);
        k = FRAME - m_rem;
        if (m_rem == 0)        m_tx = 1'b1;
        else if (k / R == 0)   m_tx = 1'b0;
        else if (k / R <= 8)   m_tx = m_cur[k / R - 1];
        else                   m_tx = 1'b1;
        m_busy  = (m_rem != 0);
        m_level = m_q.size();
        m_full  = (m_q.size() == DEPTH);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        tx_wr   = 1'b1;
        tx_byte = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0 || tx_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state tx=%b busy=%b level=%0d full=%b required 1 0 0 0",
                     tx, tx_busy, fifo_level, tx_full);
        end
        tx_wr = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00);
            checks++;
            if (tx !== m_tx || tx_busy !== m_busy || fifo_level !== 3'(m_level) || tx_full !== m_full) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d tx=%b/%b busy=%b/%b level=%0d/%0d full=%b/%b",
                         i, tx, m_tx, tx_busy, m_busy, fifo_level, m_level, tx_full, m_full);
            end
        end
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        cycle(1'b1, 8'hA5);
        checks++;
        if (fifo_level !== 3'd1 || tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after_write level=%0d tx=%b busy=%b required 1 1 0",
                     fifo_level, tx, tx_busy);
        end
        for (int i = 0; i < FRAME + 10; i++) begin
            cycle(1'b0, 8'h00);
            if (tx_busy === 1'b1) busy_cnt++;
            checks++;
            if (tx !== m_tx || tx_busy !== m_busy || fifo_level !== 3'(m_level) || tx_full !== m_full) begin
                errors++;
                $display("FAIL single cyc=%0d tx=%b/%b busy=%b/%b level=%0d/%0d full=%b/%b",
                         i, tx, m_tx, tx_busy, m_busy, fifo_level, m_level, tx_full, m_full);
            end
        end
        checks++;
        if (busy_cnt != FRAME) begin
            errors++;
            $display("FAIL single_busy_len got=%0d required=%0d", busy_cnt, FRAME);
        end
    endtask

    task automatic test_fill();
        int busy_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 8'(i));
            checks++;
            if (tx !== m_tx || tx_busy !== m_busy || fifo_level !== 3'(m_level) || tx_full !== m_full) begin
                errors++;
                $display("FAIL fill_write n=%0d tx=%b/%b busy=%b/%b level=%0d/%0d full=%b/%b",
                         i, tx, m_tx, tx_busy, m_busy, fifo_level, m_level, tx_full, m_full);
            end
            if (i == 5) begin
                checks++;
                if (tx_full !== 1'b1 || fifo_level !== 3'd4) begin
                    errors++;
                    $display("FAIL fill_full full=%b level=%0d required 1 4", tx_full, fifo_level);
                end
            end
            if (tx_busy === 1'b1) busy_cnt++;
        end
        for (int i = 0; i < 1000 && tx_busy === 1'b1; i++) begin
            cycle(1'b0, 8'h00);
            if (tx_busy === 1'b1) busy_cnt++;
            checks++;
            if (tx !== m_tx || tx_busy !== m_busy || fifo_level !== 3'(m_level) || tx_full !== m_full) begin
                errors++;
                $display("FAIL fill_drain cyc=%0d tx=%b/%b busy=%b/%b level=%0d/%0d full=%b/%b",
                         i, tx, m_tx, tx_busy, m_busy, fifo_level, m_level, tx_full, m_full);
            end
        end
        checks++;
        if (busy_cnt != 5 * FRAME || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_total busy_cycles=%0d required=%0d busy_now=%b",
                     busy_cnt, 5 * FRAME, tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        bit written = 0;
        cycle(1'b1, 8'h11);
        for (int i = 0; i < 3 * FRAME && (tx_busy === 1'b1 || !written); i++) begin
            if (!written && m_rem == R / 2) begin
                cycle(1'b1, 8'h22);
                written = 1;
            end else begin
                cycle(1'b0, 8'h00);
            end
            if (tx_busy === 1'b1) busy_cnt++;
            checks++;
            if (tx !== m_tx || tx_busy !== m_busy || fifo_level !== 3'(m_level) || tx_full !== m_full) begin
                errors++;
                $display("FAIL b2b cyc=%0d tx=%b/%b busy=%b/%b level=%0d/%0d full=%b/%b",
                         i, tx, m_tx, tx_busy, m_busy, fifo_level, m_level, tx_full, m_full);
            end
        end
        checks++;
        if (busy_cnt != 2 * FRAME) begin
            errors++;
            $display("FAIL b2b_no_gap busy_cycles=%0d required=%0d", busy_cnt, 2 * FRAME);
        end
    endtask

    task automatic test_reset_midframe();
        cycle(1'b1, 8'h3C);
        cycle(1'b1, 8'h77);
        cycle(1'b1, 8'h88);
        for (int i = 0; i < FRAME && (FRAME - m_rem) != 50; i++)
            cycle(1'b0, 8'h00);
        rst_n = 1'b0;
        #2;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0 || tx_full !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset tx=%b busy=%b level=%0d full=%b required 1 0 0 0",
                     tx, tx_busy, fifo_level, tx_full);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle(i == FRAME, 8'h55);
            checks++;
            if (tx !== m_tx || tx_busy !== m_busy || fifo_level !== 3'(m_level) || tx_full !== m_full) begin
                errors++;
                $display("FAIL after_reset cyc=%0d tx=%b/%b busy=%b/%b level=%0d/%0d full=%b/%b",
                         i, tx, m_tx, tx_busy, m_busy, fifo_level, m_level, tx_full, m_full);
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            cycle(1'b0, 8'h00);
            checks++;
            if (tx !== m_tx || tx_busy !== m_busy || fifo_level !== 3'(m_level) || tx_full !== m_full) begin
                errors++;
                $display("FAIL after_reset_55 cyc=%0d tx=%b/%b busy=%b/%b level=%0d/%0d full=%b/%b",
                         i, tx, m_tx, tx_busy, m_busy, fifo_level, m_level, tx_full, m_full);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            logic wr;
            wr = (i < 5000) && ($urandom_range(0, 59) == 0);
            cycle(wr, 8'($urandom_range(0, 255)));
            checks++;
            if (tx !== m_tx || tx_busy !== m_busy || fifo_level !== 3'(m_level) || tx_full !== m_full) begin
                errors++;
                $display("FAIL random cyc=%0d tx=%b/%b busy=%b/%b level=%0d/%0d full=%b/%b",
                         i, tx, m_tx, tx_busy, m_busy, fifo_level, m_level, tx_full, m_full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
